fsk_frame_builder: RTL

Upstream stage of the FSK byte modulator. It buffers payload bytes from the host side into a small FIFO. When a frame is closed, it emits the framed byte stream (preamble, sync, length, payload, checksum) one byte at a time. It uses a valid/ready handshake in which out_data is held stable for the whole time the modulator serialises that byte.

---
 rtl/fsk_frame_builder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fsk_frame_builder.sv
// Framing stage ahead of the FSK byte modulator: buffers payload bytes, then emits
// preamble, sync, length, payload and checksum over a hold-until-reload byte slot.
module fsk_frame_builder #(
  parameter int         FIFO_DEPTH    = 16,
  parameter int         PREAMBLE_LEN  = 2,
  parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0] SYNC_BYTE     = 8'h7E
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PRE_W = $clog2(PREAMBLE_LEN + 1);

  localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_PRE,
    S_SYNC,
    S_LEN,
    S_PAY,
    S_CSUM
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_sum;
  logic [PRE_W-1:0] r_pre_cnt;
  logic             r_in_ready;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_frame_done;

  logic             w_wr;
  logic             w_close;
  logic             w_load;
  logic             w_xfer;
  logic [7:0]       w_len;
  logic [7:0]       w_cur_byte;

  // Two's complement so that length + payload + checksum sums to zero mod 256.
  function automatic logic [7:0] f_csum(input logic [7:0] sum);
    return (~sum) + 8'd1;
  endfunction

  assign w_wr    = in_valid & r_in_ready & (r_state == S_COLLECT);
  assign w_close = w_wr & (in_last | (r_count == DEPTH_M1));
  assign w_load  = (r_state != S_COLLECT) & ~r_out_valid & out_ready;
  assign w_xfer  = r_out_valid & out_ready;
  assign w_len   = 8'(r_count);

  always_comb begin
    w_cur_byte = 8'h00;
    case (r_state)
      S_PRE:   w_cur_byte = PREAMBLE_BYTE;
      S_SYNC:  w_cur_byte = SYNC_BYTE;
      S_LEN:   w_cur_byte = w_len;
      S_PAY:   w_cur_byte = r_mem[r_rd_ptr];
      S_CSUM:  w_cur_byte = f_csum(r_sum);
      default: w_cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: if (w_close) w_state_nxt = S_PRE;
      S_PRE:     if (w_xfer && (r_pre_cnt == PRE_LAST)) w_state_nxt = S_SYNC;
      S_SYNC:    if (w_xfer) w_state_nxt = S_LEN;
      S_LEN:     if (w_xfer) w_state_nxt = S_PAY;
      S_PAY:     if (w_xfer && (r_count == CNT_ONE)) w_state_nxt = S_CSUM;
      S_CSUM:    if (w_xfer) w_state_nxt = S_COLLECT;
      default:   w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_COLLECT;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_sum        <= 8'h00;
      r_pre_cnt    <= '0;
      r_in_ready   <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // Based on the current state so in_ready stays low through the frame_done cycle.
      r_in_ready   <= (r_state == S_COLLECT) & ~w_close;
      r_frame_done <= w_xfer & (r_state == S_CSUM);

      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 1'b1;
        r_sum    <= r_sum + in_data;
      end

      if (w_load) begin
        r_out_data  <= w_cur_byte;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end

      if (w_xfer) begin
        case (r_state)
          S_PRE:  r_pre_cnt <= (r_pre_cnt == PRE_LAST) ? '0 : r_pre_cnt + 1'b1;
          // Fold the length byte into the sum once it has gone out.
          S_LEN:  r_sum <= r_sum + w_len;
          S_PAY: begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count  <= r_count - 1'b1;
          end
          S_CSUM: begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_sum    <= 8'h00;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  assign in_ready   = r_in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign busy       = (r_state != S_COLLECT);
  assign frame_done = r_frame_done;

endmodule
